// File: rtl/zigzag_reorder_if.sv
// Coefficient stream in (raster order) and zigzag stream out for zigzag_reorder.
interface zigzag_reorder_if #(parameter int DATA_W = 12);
  logic              ZigZag_start;
  logic [DATA_W-1:0] DCT_data;
  logic [DATA_W-1:0] zz_data;
  logic              zz_valid;
  logic              zz_sob;
  logic              zz_eob;
  logic              blk_err;

  modport slave (
    input  ZigZag_start, DCT_data,
    output zz_data, zz_valid, zz_sob, zz_eob, blk_err
  );

  modport master (
    output ZigZag_start, DCT_data,
    input  zz_data, zz_valid, zz_sob, zz_eob, blk_err
  );
endinterface

// File: rtl/zigzag_reorder.sv
// 8x8 raster-to-zigzag reorder with ping-pong banks; back-to-back blocks, no gaps.
// Optional ZIGZAG_TRANSPOSE_EN: input arrives column-major and is transposed on write.
module zigzag_reorder #(
  parameter int DATA_W = 12
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  zigzag_reorder_if.slave zz_if
);

  localparam logic [5:0] ZZ_LUT [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef enum logic {WR_IDLE, WR_FILL}  wr_state_e;
  typedef enum logic {RD_IDLE, RD_DRAIN} rd_state_e;

  logic [DATA_W-1:0] r_mem [2][64];

  wr_state_e   r_wr_state, w_wr_state_nxt;
  logic [5:0]  r_wr_idx, w_wr_idx_nxt, w_wr_idx_cur, w_wr_addr;
  logic        r_wr_bank, w_wr_bank_nxt;
  logic        w_wr_en, w_wr_done, w_abort;

  rd_state_e   r_rd_state, w_rd_state_nxt;
  logic [5:0]  r_rd_cnt, w_rd_cnt_nxt, w_rd_addr;
  logic        r_rd_bank, w_rd_bank_nxt;
  logic        w_rd_en, w_rd_rel, w_rd_other, w_next_ready, w_cur_ready;

  logic [1:0]        r_full;
  logic [DATA_W-1:0] r_zz_data;
  logic              r_zz_valid, r_zz_sob, r_zz_eob, r_blk_err;

  // ---------------- write side ----------------
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_idx_nxt   = r_wr_idx;
    w_wr_bank_nxt  = r_wr_bank;
    w_wr_idx_cur   = r_wr_idx;
    w_wr_en        = 1'b0;
    w_wr_done      = 1'b0;
    w_abort        = 1'b0;
    if (zz_if.ZigZag_start) begin
      // a start always wins: restart at index 0 in the current bank
      w_wr_en        = 1'b1;
      w_wr_idx_cur   = 6'd0;
      w_wr_idx_nxt   = 6'd1;
      w_wr_state_nxt = WR_FILL;
      w_abort        = (r_wr_state == WR_FILL);
    end else if (r_wr_state == WR_FILL) begin
      w_wr_en = 1'b1;
      if (r_wr_idx == 6'd63) begin
        w_wr_done      = 1'b1;
        w_wr_bank_nxt  = ~r_wr_bank;
        w_wr_idx_nxt   = 6'd0;
        w_wr_state_nxt = WR_IDLE;
      end else begin
        w_wr_idx_nxt = r_wr_idx + 6'd1;
      end
    end
  end

`ifdef ZIGZAG_TRANSPOSE_EN
  assign w_wr_addr = {w_wr_idx_cur[2:0], w_wr_idx_cur[5:3]};
`else
  assign w_wr_addr = w_wr_idx_cur;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_state <= WR_IDLE;
      r_wr_idx   <= 6'd0;
      r_wr_bank  <= 1'b0;
      r_blk_err  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_wr_idx   <= w_wr_idx_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_blk_err  <= w_abort;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr_en) r_mem[r_wr_bank][w_wr_addr] <= zz_if.DCT_data;
  end

  // ---------------- read side ----------------
  // A bank completing this cycle counts as ready so the drain starts next cycle.
  assign w_rd_other   = ~r_rd_bank;
  assign w_cur_ready  = r_full[r_rd_bank] | (w_wr_done && (r_wr_bank == r_rd_bank));
  assign w_next_ready = r_full[w_rd_other] | (w_wr_done && (r_wr_bank == w_rd_other));
  assign w_rd_addr    = ZZ_LUT[r_rd_cnt];

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_bank_nxt  = r_rd_bank;
    w_rd_en        = 1'b0;
    w_rd_rel       = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (w_cur_ready) begin
          w_rd_state_nxt = RD_DRAIN;
          w_rd_cnt_nxt   = 6'd0;
        end
      end
      RD_DRAIN: begin
        w_rd_en      = 1'b1;
        w_rd_cnt_nxt = r_rd_cnt + 6'd1;
        if (r_rd_cnt == 6'd63) begin
          w_rd_rel       = 1'b1;
          w_rd_bank_nxt  = w_rd_other;
          w_rd_cnt_nxt   = 6'd0;
          w_rd_state_nxt = w_next_ready ? RD_DRAIN : RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= 6'd0;
      r_rd_bank  <= 1'b0;
      r_full     <= 2'b00;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_rd_bank  <= w_rd_bank_nxt;
      if (w_rd_rel)  r_full[r_rd_bank] <= 1'b0;
      if (w_wr_done) r_full[r_wr_bank] <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_zz_data  <= '0;
      r_zz_valid <= 1'b0;
      r_zz_sob   <= 1'b0;
      r_zz_eob   <= 1'b0;
    end else begin
      if (w_rd_en) r_zz_data <= r_mem[r_rd_bank][w_rd_addr];
      r_zz_valid <= w_rd_en;
      r_zz_sob   <= w_rd_en && (r_rd_cnt == 6'd0);
      r_zz_eob   <= w_rd_en && (r_rd_cnt == 6'd63);
    end
  end

  assign zz_if.zz_data  = r_zz_data;
  assign zz_if.zz_valid = r_zz_valid;
  assign zz_if.zz_sob   = r_zz_sob;
  assign zz_if.zz_eob   = r_zz_eob;
  assign zz_if.blk_err  = r_blk_err;

endmodule

// File: tb/tb_zigzag_reorder.sv
// Scoreboard bench for zigzag_reorder: expected zigzag stream queued per block, checked at output.
module tb_zigzag_reorder;
  localparam int DW = 12;

  localparam int ZZ [64] = '{
    0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
   12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
   35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
   58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

  typedef struct {
    logic [DW-1:0] data;
    logic          sob;
    logic          eob;
    int            cyc;
  } exp_t;

  logic sys_clk, sys_rst_n;
  zigzag_reorder_if #(.DATA_W(DW)) bus();

  zigzag_reorder #(.DATA_W(DW)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .zz_if     (bus.slave)
  );

  exp_t          sb [$];
  logic [DW-1:0] blk_v [64];
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;
  int            err_cnt = 0;
  int            err_cyc = -1;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc++;

  // position in the input stream that carries true raster element a
  function automatic int src_pos(input int a);
`ifdef ZIGZAG_TRANSPOSE_EN
    return (a % 8) * 8 + a / 8;
`else
    return a;
`endif
  endfunction

  // Output monitor: every valid beat is compared against the scoreboard head.
  always @(negedge sys_clk) begin
    exp_t e;
    if (sys_rst_n) begin
      if (bus.blk_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
      if ((bus.zz_sob || bus.zz_eob) && !bus.zz_valid) begin
        checks++; failures++;
        $display("FAIL flag_without_valid cyc=%0d sob=%b eob=%b", cyc, bus.zz_sob, bus.zz_eob);
      end
      if (bus.zz_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid cyc=%0d data=%0d expected no output", cyc, $signed(bus.zz_data));
        end else begin
          e = sb.pop_front();
          if (bus.zz_data !== e.data || bus.zz_sob !== e.sob || bus.zz_eob !== e.eob || cyc != e.cyc) begin
            failures++;
            $display("FAIL zz_beat got data=%0d sob=%b eob=%b cyc=%0d expected data=%0d sob=%b eob=%b cyc=%0d",
                     $signed(bus.zz_data), bus.zz_sob, bus.zz_eob, cyc,
                     $signed(e.data), e.sob, e.eob, e.cyc);
          end
        end
      end
    end
  end

  // Drives n samples of blk_v with start on the first; a full block queues its expected output.
  task automatic drive_block(input int n, output int s_cyc);
    exp_t e;
    s_cyc = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      bus.ZigZag_start = (i == 0);
      bus.DCT_data     = blk_v[i];
      if (i == 0) s_cyc = cyc;
    end
    if (n == 64) begin
      for (int k = 0; k < 64; k++) begin
        e.data = blk_v[src_pos(ZZ[k])];
        e.sob  = (k == 0);
        e.eob  = (k == 63);
        e.cyc  = s_cyc + 65 + k;
        sb.push_back(e);
      end
    end
    @(negedge sys_clk);
    bus.ZigZag_start = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst_n        = 1'b0;
    bus.ZigZag_start = 1'b0;
    bus.DCT_data     = '0;
    repeat (3) @(posedge sys_clk);
    #1;
    checks++; if (bus.zz_data  !== '0)   begin failures++; $display("FAIL reset_data got=%h want=0", bus.zz_data); end
    checks++; if (bus.zz_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.zz_valid); end
    checks++; if (bus.zz_sob   !== 1'b0) begin failures++; $display("FAIL reset_sob got=%b want=0", bus.zz_sob); end
    checks++; if (bus.zz_eob   !== 1'b0) begin failures++; $display("FAIL reset_eob got=%b want=0", bus.zz_eob); end
    checks++; if (bus.blk_err  !== 1'b0) begin failures++; $display("FAIL reset_blk_err got=%b want=0", bus.blk_err); end
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic test_single;
    int s;
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(i);
    drive_block(64, s);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL single_drain left=%0d want=0", sb.size()); end
    @(negedge sys_clk);
    checks++;
    if (bus.zz_valid !== 1'b0) begin failures++; $display("FAIL single_idle_valid got=%b want=0", bus.zz_valid); end
  endtask

  task automatic test_back_to_back;
    int s1, s2, s3;
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(i);
    drive_block(64, s1);
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(100 + i);
    // drive_block spends one trailing cycle; rewind by issuing the next start in that slot
    drive_b2b(s2);
    for (int i = 0; i < 64; i++) blk_v[i] = DW'($urandom_range(0, 4095));
    drive_b2b(s3);
    checks++;
    if (s2 != s1 + 64 || s3 != s2 + 64) begin
      failures++; $display("FAIL b2b_spacing got=%0d,%0d want=64,64", s2 - s1, s3 - s2);
    end
    for (int t = 0; t < 300 && sb.size() != 0; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL b2b_drain left=%0d want=0", sb.size()); end
  endtask

  // Like drive_block but the first sample lands in the trailing idle cycle of the previous call.
  task automatic drive_b2b(output int s_cyc);
    exp_t e;
    s_cyc = cyc;
    bus.ZigZag_start = 1'b1;
    bus.DCT_data     = blk_v[0];
    for (int i = 1; i < 64; i++) begin
      @(negedge sys_clk);
      bus.ZigZag_start = 1'b0;
      bus.DCT_data     = blk_v[i];
    end
    for (int k = 0; k < 64; k++) begin
      e.data = blk_v[src_pos(ZZ[k])];
      e.sob  = (k == 0);
      e.eob  = (k == 63);
      e.cyc  = s_cyc + 65 + k;
      sb.push_back(e);
    end
    @(negedge sys_clk);
    bus.ZigZag_start = 1'b0;
  endtask

  task automatic test_abort;
    int s1, s2;
    err_cnt = 0;
    err_cyc = -1;
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(50 + i);
    drive_block(20, s1);
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(200 + i);
    drive_b2b(s2);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL abort_drain left=%0d want=0", sb.size()); end
    checks++;
    if (err_cnt != 1) begin failures++; $display("FAIL abort_err_count got=%0d want=1", err_cnt); end
    checks++;
    if (err_cyc != s2 + 1) begin failures++; $display("FAIL abort_err_cycle got=%0d want=%0d", err_cyc, s2 + 1); end
  endtask

  task automatic test_extremes;
    int s;
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(i * 37 - 1100);
    blk_v[src_pos(0)]  = 12'h800;
    blk_v[src_pos(8)]  = 12'hFFF;
    blk_v[src_pos(63)] = 12'h7FF;
    drive_block(64, s);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL extremes_drain left=%0d want=0", sb.size()); end
  endtask

  task automatic test_reset_mid_drain;
    int s, vcount;
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(300 + i);
    drive_block(64, s);
    for (int t = 0; t < 200 && sb.size() > 34; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 34) begin failures++; $display("FAIL middrain_reach left=%0d want=34", sb.size()); end
    @(posedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.zz_valid !== 1'b0 || bus.zz_data !== '0 || bus.zz_sob !== 1'b0 || bus.zz_eob !== 1'b0) begin
      failures++;
      $display("FAIL middrain_async_reset got valid=%b data=%h sob=%b eob=%b want all 0",
               bus.zz_valid, bus.zz_data, bus.zz_sob, bus.zz_eob);
    end
    sb.delete();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    vcount = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge sys_clk);
      if (bus.zz_valid) vcount++;
    end
    checks++;
    if (vcount != 0) begin failures++; $display("FAIL post_reset_quiet got=%0d valid cycles want=0", vcount); end
    for (int i = 0; i < 64; i++) blk_v[i] = DW'(1000 - i * 5);
    drive_block(64, s);
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge sys_clk);
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL post_reset_drain left=%0d want=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_extremes();
    test_reset_mid_drain();
    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
